// File: rtl/freq_meter_if.sv
// Signal bundle between the frequency meter and its user.
// valid is a one-cycle strobe with no back-pressure: count/ovf change only when it pulses, so sample them then.
interface freq_meter_if #(
   parameter int CNT_W = 24
);
   logic             sig_in;
   logic             start;
   logic             cont;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             valid;
   logic             busy;
   logic             state_dbg;

   modport master (
      output sig_in, start, cont,
      input  count, ovf, valid, busy, state_dbg
   );

   modport slave (
      input  sig_in, start, cont,
      output count, ovf, valid, busy, state_dbg
   );
endinterface

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a GATE_CYCLES clk window,
// with one-shot or back-to-back continuous windows and saturation reporting.
module freq_meter #(
   parameter int GATE_CYCLES = 1000000,
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input logic         clk,
   input logic         rst_n,
   freq_meter_if.slave bus
);

   localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   armed_q;
   logic [GW-1:0]          gate_cnt_q;
   logic [CNT_W-1:0]       edge_cnt_q;
   logic                   sat_q;
   logic [CNT_W-1:0]       count_q;
   logic                   ovf_q;
   logic                   valid_q;

   logic                   rise;
   logic                   at_max;
   logic                   sat_hit;
   logic [CNT_W-1:0]       edge_next;
   logic                   terminal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign at_max    = (edge_cnt_q == CNT_MAX);
   assign sat_hit   = rise & at_max;
   assign edge_next = (rise && !at_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

   // armed_q masks requests on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         armed_q <= 1'b1;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      terminal = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && (bus.start || bus.cont)) state_d = GATE;
         end
         GATE: begin
            if (gate_cnt_q == GATE_LAST) begin
               terminal = 1'b1;
               if (!bus.cont) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The terminal cycle's rise is folded into the reported count, so no edge is lost across windows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (state_q == GATE) begin
            if (terminal) begin
               count_q    <= edge_next;
               ovf_q      <= sat_q | sat_hit;
               valid_q    <= 1'b1;
               gate_cnt_q <= '0;
               edge_cnt_q <= '0;
               sat_q      <= 1'b0;
            end else begin
               gate_cnt_q <= gate_cnt_q + GW'(1);
               edge_cnt_q <= edge_next;
               sat_q      <= sat_q | sat_hit;
            end
         end else begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
         end
      end
   end

   assign bus.count     = count_q;
   assign bus.ovf       = ovf_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state_q == GATE);
   assign bus.state_dbg = state_q;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow digital signal, such as a divided-clock LED drive, against the fabric clock.
- Counts rising edges of the asynchronous input over a fixed gate window of GATE_CYCLES clk cycles.
- Presents the edge count with a one-cycle valid strobe.
- Acts as the observing end of the counter/divider outputs: used in loopback self-test of divider taps and for measuring external signals on LA104 pins.

Parameters:
- GATE_CYCLES, 1000000: gate window length in clk cycles; must be ≥ 2.
- CNT_W, 24: width of the edge counter and result.
- SYNC_STAGES, 2: synchronizer flop count on sig_in; must be ≥ 2.

Ports:
- clk  input  1  fabric clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal to be measured.
- start  input  1  one-shot request; sampled only in IDLE.
- cont  input  1  continuous mode; while high, windows repeat back-to-back.
- count  output  CNT_W  rising edges counted in the last completed window.
- ovf  output  1  last window's edge count saturated.
- valid  output  1  one-cycle strobe marking a new count/ovf.
- busy  output  1  high while a gate window is running.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - synchronizer flops, edge-detect flop, gate_cnt and edge_cnt are 0;
  - state=IDLE;
  - count=0, ovf=0, valid=0, busy=0.
- Synchronizer:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist.
  - A sig_in rising edge asserts rise SYNC_STAGES+1 cycles after the edge, at most.
  - Max measurable rate is one rising edge per 2 clk; faster inputs alias (documented, not checked).
- State IDLE:
  - busy=0, counters held at 0.
  - If start=1 or cont=1 at a clk edge: go to GATE with gate_cnt=0 and edge_cnt=0. busy=1 from the next cycle.
- State GATE:
  - busy=1; gate_cnt increments every cycle.
  - Each cycle with rise=1 increments edge_cnt.
  - Saturation: edge_cnt saturates at 2^CNT_W-1. An increment at saturation sets an internal sat flag.
  - Terminal cycle is gate_cnt == GATE_CYCLES-1. A rise in that cycle is included. Exactly GATE_CYCLES cycles are sampled per window.
  - At the edge ending the terminal cycle:
    - count <= saturating(edge_cnt + rise);
    - ovf <= sat | (edge_cnt at max & rise);
    - valid <= 1 for exactly one cycle;
    - gate_cnt, edge_cnt and sat clear.
  - Next state after the terminal edge: cont=1 (sampled on the terminal cycle) → stay in GATE, so the next window starts immediately with no dead cycle and no lost edges. Otherwise → IDLE.
- start while in GATE is ignored; it is neither queued nor restarts the window.
- cont dropping mid-window: the current window completes and reports, then the block goes to IDLE.
- count and ovf hold their values between valid strobes.
- Reset asserted mid-window: the window is abandoned, outputs clear, and no valid is issued.
- A start pulse arriving in the same cycle as reset deassertion is ignored.

Test Plan:
- GATE_CYCLES=100, CNT_W=24: sig_in toggles every 5 clk (period 10), pulse start → one valid pulse with count=10, ovf=0, busy high for exactly 100 cycles.
- sig_in held at 0, then at 1, one-shot each time → count=0 both times. A constant-high input produces no edges after sync settles.
- CNT_W=4, GATE_CYCLES=100: sig_in period 2 clk → count=15, ovf=1. Next window with period 20 → count=5, ovf=0.
- cont=1 with sig_in period 4 for 3 windows → valid strobes spaced exactly 100 cycles apart, each with count=25. Drop cont mid-third window → third report occurs, then busy=0.
- Assert rst_n=0 at cycle 50 of a window → count=0, valid never pulses, busy=0. After release, start gives a correct fresh count.
- Pulse start again at cycle 30 of a running window → no restart; the window ends at cycle 100 with a single valid.
